packet_rr_arbiter: RTL and testbench

- Output-port arbiter for the custom router: shares one output link between NREQ packet_sender-style input ports.
- Grants whole packets round-robin and parses the header (SRC, DST, SIZE, DATA..., CRC) to find packet end.
- Multiplexes the granted port's byte stream onto the link, with valid/ready backpressure.

---
 rtl/router_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/packet_rr_arbiter.sv | 117 +++++++++++
 tb/tb_packet_rr_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet header layout, size-field width and the
// output-arbiter state encoding.
package router_pkg;

    localparam int SIZE_BITS = 3;

    localparam logic [1:0] OFS_SRC_ID = 2'd0;
    localparam logic [1:0] OFS_DST_ID = 2'd1;
    localparam logic [1:0] OFS_SIZE   = 2'd2;
    localparam logic [1:0] OFS_DATA   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winner_idx,
    output logic            any
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [PW-1:0] idx_s;

    // Scan from lowest to highest priority so the rr_ptr slot is written last.
    always_comb begin
        any        = |req;
        winner_idx = '0;
        idx_s      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s      = PW'((32'(rr_ptr) + 32'(k)) % NREQ);
            winner_idx = req[idx_s] ? idx_s : winner_idx;
        end
        winner = any ? (ONE << winner_idx) : '0;
    end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Output-port arbiter: grants whole packets round-robin, tracks the header to
// find the CRC byte, and muxes the granted port onto the link.
module packet_rr_arbiter
    import router_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int UWIDTH    = 8,
    parameter int SIZE_BITS = router_pkg::SIZE_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        in_valid,
    input  logic [NREQ*UWIDTH-1:0] in_data,
    output logic [NREQ-1:0]        in_ready,
    output logic [NREQ-1:0]        grant,
    output logic                   out_valid,
    output logic [UWIDTH-1:0]      out_data,
    input  logic                   out_ready,
    output logic                   out_sop,
    output logic                   out_eop
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e            state_r;
    logic [NREQ-1:0]       grant_r;
    logic [PW-1:0]         gidx_r;
    logic [PW-1:0]         rr_ptr_r;
    logic [1:0]            byte_cnt_r;
    logic [SIZE_BITS-1:0]  dsz_r;

    logic [NREQ-1:0]       pick_onehot_s;
    logic [PW-1:0]         pick_idx_s;
    logic                  pick_any_s;
    logic                  out_valid_s;
    logic [UWIDTH-1:0]     out_data_s;
    logic                  beat_s;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr_r),
        .winner     (pick_onehot_s),
        .winner_idx (pick_idx_s),
        .any        (pick_any_s)
    );

    // AND-OR mux of the granted port; an all-zero grant yields zero outputs.
    always_comb begin
        out_valid_s = 1'b0;
        out_data_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            out_valid_s = out_valid_s | (grant_r[i] & in_valid[i]);
            out_data_s  = out_data_s | (in_data[i*UWIDTH +: UWIDTH] & {UWIDTH{grant_r[i]}});
        end
    end

    assign beat_s    = out_valid_s & out_ready;
    assign out_valid = out_valid_s;
    assign out_data  = out_data_s;
    assign grant     = grant_r;
    assign in_ready  = {NREQ{out_ready}} & grant_r;
    assign out_sop   = out_valid_s & (state_r == ST_HDR) & (byte_cnt_r == OFS_SRC_ID);
    assign out_eop   = out_valid_s & (state_r == ST_CRC);

    // Packet FSM: arbitrate in IDLE, then follow header/payload/CRC on beats only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            rr_ptr_r   <= '0;
            byte_cnt_r <= 2'd0;
            dsz_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant_r    <= pick_onehot_s;
                        gidx_r     <= pick_idx_s;
                        byte_cnt_r <= 2'd0;
                        state_r    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (beat_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == OFS_SIZE) begin
                            dsz_r   <= out_data_s[SIZE_BITS-1:0];
                            state_r <= (out_data_s[SIZE_BITS-1:0] != '0) ? ST_DATA : ST_CRC;
                        end
                    end
                end
                ST_DATA: begin
                    if (beat_s) begin
                        dsz_r <= dsz_r - SIZE_BITS'(1);
                        if (dsz_r == SIZE_BITS'(1)) begin
                            state_r <= ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (beat_s) begin
                        grant_r  <= '0;
                        rr_ptr_r <= (gidx_r == PW'(NREQ - 1)) ? '0 : gidx_r + PW'(1);
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    grant_r <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Scoreboard bench for packet_rr_arbiter: port models feed byte queues, the
// expected link stream is queued at load time and checked beat by beat.
module tb_packet_rr_arbiter;

    localparam int NREQ = 4;
    localparam int UW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   in_valid;
    logic [NREQ*UW-1:0] in_data;
    logic [NREQ-1:0]   in_ready;
    logic [NREQ-1:0]   grant;
    logic              out_valid;
    logic [UW-1:0]     out_data;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;

    always #5 clk = ~clk;

    packet_rr_arbiter #(.NREQ(NREQ), .UWIDTH(UW), .SIZE_BITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop)
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [3:0] gnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] pq[NREQ][$];

    int n_chk = 0, n_pass = 0, n_beats = 0, neg_cyc = 0, cyc = 0, last_eop = 0;
    bit ready_mode = 1'b0, gap_mode = 1'b0, use_ovr = 1'b1;
    bit gap_chk = 1'b0, have_eop = 1'b0, post_eop = 1'b0, prev_stall = 1'b0;
    logic [3:0] ovr = 4'b1111;
    logic [3:0] acc = 4'b0000;
    logic [3:0] rpat = 4'b1001;
    logic [7:0] stall_data = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    endtask

    task automatic pkt(input int p, input logic [7:0] dst, input int dsz,
                       input logic [7:0] base, input logic [7:0] crc, input int n_exp);
        int n;
        logic [7:0] b;
        n = 4 + dsz;
        for (int k = 0; k < n; k++) begin
            if (k == 0)          b = 8'(p);
            else if (k == 1)     b = dst;
            else if (k == 2)     b = 8'(dsz);
            else if (k == n - 1) b = crc;
            else                 b = base + 8'(k - 3);
            pq[p].push_back(b);
            if (k < n_exp) exp_q.push_back('{data: b, sop: (k == 0), eop: (k == n - 1), gnt: 4'(1 << p)});
        end
    endtask

    function automatic bit ports_empty();
        bit r = 1'b1;
        for (int i = 0; i < NREQ; i++) if (pq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int t = 0;
        while (t < budget && !(exp_q.size() == 0 && grant == 4'b0000 && ports_empty())) begin
            @(posedge clk);
            t++;
        end
        check_val("drain_exp_q", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Port models: retire accepted bytes, then present the next byte/req.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                bit v, gap;
                if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                v   = (pq[i].size() > 0);
                gap = gap_mode && ($urandom_range(0, 2) == 0);
                in_valid[i]        = v && !gap;
                in_data[i*UW +: UW] = v ? pq[i][0] : 8'h00;
                req[i]             = use_ovr ? ovr[i] : v;
            end
            out_ready = ready_mode ? rpat[cyc % 4] : 1'b1;
        end
    end

    // Link monitor: scoreboard compare per beat, stall stability, gaps.
    always @(negedge clk) begin
        neg_cyc++;
        acc = in_valid & in_ready;
        if (post_eop) begin
            check_val("grant_clear_after_eop", grant, 4'b0000);
            post_eop = 1'b0;
        end
        if (!rst && out_valid && out_ready) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_val("out_data", out_data, e.data);
                check_val("out_sop", out_sop, e.sop);
                check_val("out_eop", out_eop, e.eop);
                check_val("grant", grant, e.gnt);
                if (e.sop && gap_chk && have_eop) check_val("idle_gap", neg_cyc - last_eop, 2);
                if (e.eop) begin
                    post_eop = 1'b1;
                    last_eop = neg_cyc;
                    have_eop = 1'b1;
                end
            end
        end
        if (!rst && prev_stall && out_valid) check_val("stall_stable", out_data, stall_data);
        if (!rst && out_valid && !out_ready) begin
            check_val("stall_in_ready", in_ready, 4'b0000);
            stall_data = out_data;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int target, budget;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        req       = ovr;

        // Reset with every port requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_grant", grant, 4'b0000);
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_in_ready", in_ready, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("release_grant", grant, 4'b0001);
        @(posedge clk);
        #1 use_ovr = 1'b0;
        do_reset();

        // Single 7-byte packet on port 2, then ports 3 and 0 together (rr_ptr=3).
        pkt(2, 8'h05, 3, 8'hA1, 8'hCC, 99);
        wait_idle(100);
        pkt(3, 8'h30, 0, 8'h00, 8'hD3, 99);
        pkt(0, 8'h31, 0, 8'h00, 8'hD0, 99);
        wait_idle(100);

        // Zero-payload packet on port 0.
        pkt(0, 8'h01, 0, 8'h00, 8'h5A, 99);
        wait_idle(100);

        // Contention on ports 0,1,3 from rr_ptr=0: order 0,1,3,0.
        do_reset();
        gap_chk  = 1'b1;
        have_eop = 1'b0;
        pkt(0, 8'h10, 0, 8'h00, 8'hE0, 99);
        pkt(1, 8'h11, 0, 8'h00, 8'hE1, 99);
        pkt(3, 8'h13, 0, 8'h00, 8'hE3, 99);
        pkt(0, 8'h20, 0, 8'h00, 8'hE4, 99);
        wait_idle(200);
        gap_chk = 1'b0;

        // Backpressure and valid gaps; rr_ptr=1 so port 1 then port 2.
        ready_mode = 1'b1;
        gap_mode   = 1'b1;
        pkt(1, 8'h07, 3, 8'hB1, 8'hDD, 99);
        pkt(2, 8'h08, 1, 8'hC1, 8'hEE, 99);
        wait_idle(400);
        ready_mode = 1'b0;
        gap_mode   = 1'b0;

        // Lone requester re-granted after one idle cycle.
        gap_chk  = 1'b1;
        have_eop = 1'b0;
        pkt(2, 8'h09, 0, 8'h00, 8'hF1, 99);
        pkt(2, 8'h0A, 2, 8'h61, 8'hF2, 99);
        wait_idle(200);
        gap_chk = 1'b0;

        // Abort a 9-byte packet on port 3 after 3 beats (rr_ptr=3 beforehand).
        target = n_beats + 3;
        pkt(3, 8'h40, 5, 8'h41, 8'h4F, 3);
        budget = 0;
        while (n_beats < target && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        check_val("abort_beats_reached", n_beats, target);
        #1 rst = 1'b1;
        pq[3].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_grant", grant, 4'b0000);
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_exp_q", exp_q.size(), 0);
        @(posedge clk);
        #1;
        pkt(0, 8'h50, 0, 8'h00, 8'h70, 99);
        pkt(3, 8'h53, 0, 8'h00, 8'h73, 99);
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
